dsp_mac_sequencer: RTL
======================

// Module: dsp_mac_sequencer
// PURPOSE
//   Drives one top_DSP48A1 slice as a streaming multiply-accumulate (dot-product) engine.
//   Accepts (a,b,last) terms on a valid/ready stream and generates OPMODE and clock enables.
//   A tag pipeline aligns OPMODE and CEP with each product at the post-adder, so input bubbles are tolerated.
//   Returns the 48-bit sum on a valid/ready result port. One job in flight at a time.
// PARAMETERS
//   MUL_LAT    3     cycles from dsp_a/dsp_b valid at slice pins to product at post-adder input (>= 1+OPMODE_REG)
//   OPMODE_REG 1     1 = slice OPMODE is registered (OPMODEREG=1); opmode then issued one cycle before CEP
//   MAX_TERMS  4096  terms per job before forced termination; product sum fits 48 bits up to 4096
//   CNT_W      13    width of term counter (must hold MAX_TERMS)
// PORTS
//   clk          in   1   clock
//   rst_n        in   1   asynchronous active-low reset
//   abort        in   1   synchronous job abort
//   in_valid     in   1   term valid
//   in_ready     out  1   sequencer accepts term
//   in_a         in   18  signed multiplicand
//   in_b         in   18  signed multiplier
//   in_last      in   1   final term of job
//   dsp_a        out  18  to slice A
//   dsp_b        out  18  to slice B (B_INPUT="DIRECT")
//   dsp_opmode   out  8   to slice OPMODE
//   dsp_ce_pipe  out  1   to slice CEA/CEB/CEM/CEOPMODE
//   dsp_cep      out  1   to slice CEP
//   dsp_rstp     out  1   to slice RSTP
//   dsp_p        in   48  from slice P
//   res_valid    out  1   result valid
//   res_ready    in   1   result consumed
//   res_data     out  48  signed dot product
//   res_count    out  CNT_W  terms in job
//   res_err      out  1   job hit MAX_TERMS without in_last
// BEHAVIOUR
//   Reset values
//   - All outputs 0 except dsp_ce_pipe=1. FSM=IDLE; tag pipe and counter cleared.
//   Input stage and tags
//   - Accepted term (in_valid & in_ready) is registered onto dsp_a/dsp_b.
//   - Tag {vld, first, last} enters tag[0] on the same edge; tag[0..MUL_LAT] shifts every cycle.
//   - Cycles with no accepted term insert vld=0; dsp_a/dsp_b hold their value.
//   Slice control
//   - dsp_ce_pipe=1 always, so slice pipeline stages advance every cycle.
//   - dsp_cep = tag[MUL_LAT].vld.
//   - dsp_opmode decoded from tag[MUL_LAT-OPMODE_REG]:
//       vld & first  -> 8'h01 (X=M, Z=0, add, CIN=0)
//       vld & ~first -> 8'h09 (X=M, Z=P)
//       ~vld         -> hold previous value
//   - A first term always clears the accumulation, so no stale P carries over between jobs.
//   FSM
//   - IDLE: in_ready=1. On an accepted term go to ACCUM, set count=1.
//     If that term has in_last (or MAX_TERMS==1), go straight to DRAIN.
//   - ACCUM: in_ready=1. Count increments on each accepted term.
//     Go to DRAIN on in_last, or when count reaches MAX_TERMS; the latter sets the err latch.
//   - DRAIN: in_ready=0. When the last tag's P update is visible on dsp_p (cycle after tag[MUL_LAT].last):
//       capture dsp_p into res_data, count into res_count, err into res_err; go to DONE.
//   - DONE: res_valid=1 and outputs held stable until res_valid & res_ready, then IDLE.
//     in_ready=0 throughout DONE.
//   Latency and boundaries
//   - Latency: res_valid rises MUL_LAT+3 cycles after the edge accepting the last term.
//   - Next job's first term can be accepted the cycle after the result handshake.
//   - abort (any state): tag pipe cleared (dsp_cep=0 from next cycle), res_valid=0, count/err cleared.
//     dsp_rstp pulses 1 cycle; FSM to IDLE. abort wins over simultaneous in/res handshakes.
//   - rst_n low mid-job: asynchronous return to reset values; no partial result emitted.
//   - Arithmetic: 18x18 signed product, 48-bit two's-complement sum. No saturation; wraps mod 2^48.
// TESTING
//   Dot product: a={1,2,3,4}, b={5,6,7,8} back-to-back
//     -> res_data=70, res_count=4, res_err=0; res_valid at last edge+6 (MUL_LAT=3).
//   Single term: a=-3, b=7, last on first term
//     -> one dsp_cep pulse with opmode 8'h01; res_data=48'hFFFF_FFFF_FFEB.
//   Bubbles: test 1 with in_valid low on alternate cycles
//     -> res_data=70; dsp_cep high exactly 4 cycles.
//   Backpressure: res_ready low 10 cycles
//     -> res_data/res_valid stable, in_ready=0; next job accepted the cycle after handshake.
//   Abort after 2 of 4 terms, then job {1,1,1}x{2,2,2}
//     -> no result for aborted job; second job res_data=6.
//   MAX_TERMS=4, 4 terms of 1x1, no in_last
//     -> res_data=4, res_count=4, res_err=1; in_ready=0 after 4th term.

Source files
------------

// File: rtl/dsp_mac_sequencer_if.sv
// Bundles for dsp_mac_sequencer: input term stream, result stream and DSP48A1 slice control.
interface mac_term_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] in_a;
    logic signed [17:0] in_b;
    logic               in_last;

    modport master (output in_valid, in_a, in_b, in_last, input in_ready);
    modport slave  (input in_valid, in_a, in_b, in_last, output in_ready);
endinterface

interface mac_res_if #(parameter int CNT_W = 13);
    logic               res_valid;
    logic               res_ready;
    logic signed [47:0] res_data;
    logic [CNT_W-1:0]   res_count;
    logic               res_err;

    modport master (output res_valid, res_data, res_count, res_err, input res_ready);
    modport slave  (input res_valid, res_data, res_count, res_err, output res_ready);
endinterface

interface dsp_slice_if;
    logic signed [17:0] dsp_a;
    logic signed [17:0] dsp_b;
    logic [7:0]         dsp_opmode;
    logic               dsp_ce_pipe;
    logic               dsp_cep;
    logic               dsp_rstp;
    logic signed [47:0] dsp_p;

    modport master (output dsp_a, dsp_b, dsp_opmode, dsp_ce_pipe, dsp_cep, dsp_rstp, input dsp_p);
    modport slave  (input dsp_a, dsp_b, dsp_opmode, dsp_ce_pipe, dsp_cep, dsp_rstp, output dsp_p);
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Streaming dot-product sequencer for one DSP48A1 slice: a tag pipeline matched to the multiply
// latency times OPMODE/CEP per product, and the 48-bit sum is returned on a result handshake.
module dsp_mac_sequencer #(
    parameter int MUL_LAT    = 3,
    parameter int OPMODE_REG = 1,
    parameter int MAX_TERMS  = 4096,
    parameter int CNT_W      = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    mac_term_if.slave   term,
    mac_res_if.master   res,
    dsp_slice_if.master dsp
);
    localparam int               OP_IDX    = MUL_LAT - OPMODE_REG;
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_TERMS);
    localparam logic [7:0]       OPM_FIRST = 8'h01;
    localparam logic [7:0]       OPM_ACC   = 8'h09;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    state_t             state_q;
    tag_t               tag_q [MUL_LAT+1];
    tag_t               tag_d;
    logic signed [17:0] a_q, b_q;
    logic [7:0]         opmode_q, opmode_d;
    logic               rstp_q;
    logic               inReady_q;
    logic               accept, reachMax, closing;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q;
    logic [1:0]         settle_q;
    logic               resValid_q, resErr_q;
    logic signed [47:0] resData_q;
    logic [CNT_W-1:0]   resCount_q;

    // A closing term is the one that ends the job, either by in_last or by hitting MAX_TERMS.
    assign accept   = term.in_valid & inReady_q & ~abort;
    assign count_d  = count_q + 1'b1;
    assign reachMax = (state_q == IDLE) ? (MAX_TERMS == 1) : (count_d == MAX_CNT);
    assign closing  = accept & (term.in_last | reachMax);

    assign tag_d.vld   = accept;
    assign tag_d.first = accept & (state_q == IDLE);
    assign tag_d.last  = closing;

    assign opmode_d = !tag_q[OP_IDX].vld ? opmode_q :
                      (tag_q[OP_IDX].first ? OPM_FIRST : OPM_ACC);

    assign term.in_ready   = inReady_q;
    assign dsp.dsp_a       = a_q;
    assign dsp.dsp_b       = b_q;
    assign dsp.dsp_opmode  = opmode_d;
    assign dsp.dsp_ce_pipe = 1'b1;
    assign dsp.dsp_cep     = tag_q[MUL_LAT].vld;
    assign dsp.dsp_rstp    = rstp_q;
    assign res.res_valid   = resValid_q;
    assign res.res_data    = resData_q;
    assign res.res_count   = resCount_q;
    assign res.res_err     = resErr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            for (int i = 0; i <= MUL_LAT; i++) tag_q[i] <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opmode_q   <= '0;
            rstp_q     <= 1'b0;
            inReady_q  <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
            settle_q   <= '0;
            resValid_q <= 1'b0;
            resData_q  <= '0;
            resCount_q <= '0;
            resErr_q   <= 1'b0;
        end else begin
            rstp_q   <= abort;
            opmode_q <= opmode_d;
            if (abort) begin
                for (int i = 0; i <= MUL_LAT; i++) tag_q[i] <= '0;
                settle_q   <= '0;
                state_q    <= IDLE;
                inReady_q  <= 1'b1;
                count_q    <= '0;
                err_q      <= 1'b0;
                resValid_q <= 1'b0;
            end else begin
                tag_q[0] <= tag_d;
                for (int i = 1; i <= MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
                // dsp_p is sampled one full cycle after the final P update has settled.
                settle_q <= {settle_q[0], tag_q[MUL_LAT].vld & tag_q[MUL_LAT].last};
                if (accept) begin
                    a_q <= term.in_a;
                    b_q <= term.in_b;
                end
                case (state_q)
                    IDLE: begin
                        if (accept) count_q <= CNT_W'(1);
                        if (closing) begin
                            state_q   <= DRAIN;
                            inReady_q <= 1'b0;
                            err_q     <= ~term.in_last;
                        end else begin
                            inReady_q <= 1'b1;
                            err_q     <= 1'b0;
                            if (accept) state_q <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (accept) count_q <= count_d;
                        if (closing) begin
                            state_q   <= DRAIN;
                            inReady_q <= 1'b0;
                            err_q     <= ~term.in_last;
                        end
                    end
                    DRAIN: begin
                        if (settle_q[1]) begin
                            resData_q  <= dsp.dsp_p;
                            resCount_q <= count_q;
                            resErr_q   <= err_q;
                            resValid_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                    DONE: begin
                        if (res.res_ready) begin
                            resValid_q <= 1'b0;
                            inReady_q  <= 1'b1;
                            count_q    <= '0;
                            err_q      <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
